// File: rtl/ft232h_sync245_emu_if.sv
// ft232h_sync245_emu_if
// Bundles the FT232H synchronous-245 bus pins and the host-side byte streams
// of the FT232H emulator. "master" is the bridge/host side that drives the
// strobes and stream inputs; "slave" is the emulated chip.
interface ft232h_sync245_emu_if;
    // FT232H bus
    logic [7:0] usb_data_i;
    logic [7:0] usb_data_o;
    logic       usb_data_oe;
    logic       usb_rxf_n;
    logic       usb_txe_n;
    logic       usb_rd_n;
    logic       usb_oe_n;
    logic       usb_wr_n;
    // host -> device stream (bytes the bridge will read)
    logic [7:0] h2d_data;
    logic       h2d_valid;
    logic       h2d_ready;
    // device -> host stream (bytes the bridge has written)
    logic [7:0] d2h_data;
    logic       d2h_valid;
    logic       d2h_ready;
    // sticky bus-violation flag
    logic       protocol_err;

    modport master (
        output usb_data_i, usb_rd_n, usb_oe_n, usb_wr_n,
        output h2d_data, h2d_valid, d2h_ready,
        input  usb_data_o, usb_data_oe, usb_rxf_n, usb_txe_n,
        input  h2d_ready, d2h_data, d2h_valid, protocol_err
    );

    modport slave (
        input  usb_data_i, usb_rd_n, usb_oe_n, usb_wr_n,
        input  h2d_data, h2d_valid, d2h_ready,
        output usb_data_o, usb_data_oe, usb_rxf_n, usb_txe_n,
        output h2d_ready, d2h_data, d2h_valid, protocol_err
    );
endinterface

// File: rtl/ft232h_sync245_emu.sv
// ft232h_sync245_emu
// Device-side emulation of the FT232H synchronous 245 FIFO bus. An RX buffer
// holds host bytes for the bridge to read (show-ahead on usb_data_o), a TX
// buffer captures bridge writes for the host. Reads are throttled into
// bursts of BURST_LEN bytes separated by GAP_CYCLES of forced rxf_n high.
// Optional macro FT232H_EMU_ERRCHK_EN adds a sticky bus-protocol checker;
// without it protocol_err is tied low.
module ft232h_sync245_emu #(
    parameter int RX_AW      = 4,
    parameter int TX_AW      = 4,
    parameter int BURST_LEN  = 8,
    parameter int GAP_CYCLES = 3
) (
    input logic                    clk,
    input logic                    reset,
    ft232h_sync245_emu_if.slave    bus
);

    localparam int RX_DEPTH = 1 << RX_AW;
    localparam int TX_DEPTH = 1 << TX_AW;
    localparam logic [RX_AW:0] RX_FULL   = (RX_AW+1)'(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL   = (TX_AW+1)'(TX_DEPTH);
    localparam logic [15:0]    BURST_TGT = 16'(BURST_LEN);
    localparam logic [7:0]     GAP_INIT  = 8'(GAP_CYCLES);
    localparam bit             BURST_EN  = (BURST_LEN != 0);

    // storage (not reset: pointers/counts define validity)
    logic [7:0] rx_mem_q [RX_DEPTH];
    logic [7:0] tx_mem_q [TX_DEPTH];

    logic [RX_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RX_AW:0]   rx_cnt_q,  rx_cnt_d;
    logic [TX_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [TX_AW:0]   tx_cnt_q,  tx_cnt_d;
    logic [15:0]      burst_q,   burst_d;
    logic [7:0]       gap_q,     gap_d;
    logic             rxf_n_q,   rxf_n_d;
    logic             txe_n_q,   txe_n_d;

    logic rx_push_s, rx_pop_s, tx_push_s, tx_pop_s;
    logic h2d_ready_s, d2h_valid_s;

    // Handshake qualifiers; h2d_ready and usb_data_oe are held low during reset.
    assign h2d_ready_s = ~reset & (rx_cnt_q != RX_FULL);
    assign d2h_valid_s = (tx_cnt_q != '0);
    assign rx_push_s   = bus.h2d_valid & h2d_ready_s;
    assign rx_pop_s    = ~bus.usb_rd_n & ~bus.usb_oe_n & ~rxf_n_q;
    assign tx_push_s   = ~bus.usb_wr_n & ~txe_n_q;
    assign tx_pop_s    = d2h_valid_s & bus.d2h_ready;

    assign bus.h2d_ready   = h2d_ready_s;
    assign bus.usb_data_oe = ~reset & ~bus.usb_oe_n;
    assign bus.usb_data_o  = (rx_cnt_q != '0) ? rx_mem_q[rx_rptr_q] : 8'h00;
    assign bus.usb_rxf_n   = rxf_n_q;
    assign bus.usb_txe_n   = txe_n_q;
    assign bus.d2h_valid   = d2h_valid_s;
    assign bus.d2h_data    = d2h_valid_s ? tx_mem_q[tx_rptr_q] : 8'h00;

    // RX next state: pointers, occupancy, burst/gap throttle and rxf_n.
    always_comb begin
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        burst_d   = burst_q;
        gap_d     = gap_q;

        if (rx_push_s) begin
            rx_wptr_d = rx_wptr_q + RX_AW'(1);
        end else begin
            rx_wptr_d = rx_wptr_q;
        end

        if (rx_pop_s) begin
            rx_rptr_d = rx_rptr_q + RX_AW'(1);
        end else begin
            rx_rptr_d = rx_rptr_q;
        end

        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_cnt_d = rx_cnt_q + (RX_AW+1)'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - (RX_AW+1)'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase

        // A running gap counts down and clears the burst count as it expires;
        // otherwise each pop advances the burst and may start a gap.
        if (gap_q != 8'd0) begin
            gap_d = gap_q - 8'd1;
            if (gap_q == 8'd1) begin
                burst_d = 16'd0;
            end else begin
                burst_d = burst_q;
            end
        end else if (rx_pop_s) begin
            burst_d = burst_q + 16'd1;
            if (BURST_EN && (burst_q + 16'd1 == BURST_TGT)) begin
                gap_d = GAP_INIT;
            end else begin
                gap_d = gap_q;
            end
        end else begin
            burst_d = burst_q;
            gap_d   = gap_q;
        end

        // Draining the buffer restarts the burst.
        if (rx_cnt_d == '0) begin
            burst_d = 16'd0;
        end else begin
            burst_d = burst_d;
        end

        rxf_n_d = (rx_cnt_d == '0) | (gap_d != 8'd0);
    end

    // TX next state: pointers, occupancy and txe_n.
    always_comb begin
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;

        if (tx_push_s) begin
            tx_wptr_d = tx_wptr_q + TX_AW'(1);
        end else begin
            tx_wptr_d = tx_wptr_q;
        end

        if (tx_pop_s) begin
            tx_rptr_d = tx_rptr_q + TX_AW'(1);
        end else begin
            tx_rptr_d = tx_rptr_q;
        end

        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_cnt_d = tx_cnt_q + (TX_AW+1)'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - (TX_AW+1)'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase

        txe_n_d = (tx_cnt_d == TX_FULL);
    end

    // State registers with synchronous reset; reset discards buffered bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            burst_q   <= 16'd0;
            gap_q     <= 8'd0;
            rxf_n_q   <= 1'b1;
            txe_n_q   <= 1'b1;
        end else begin
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            burst_q   <= burst_d;
            gap_q     <= gap_d;
            rxf_n_q   <= rxf_n_d;
            txe_n_q   <= txe_n_d;
        end
    end

    // Buffer storage writes.
    always_ff @(posedge clk) begin
        if (rx_push_s) begin
            rx_mem_q[rx_wptr_q] <= bus.h2d_data;
        end
        if (tx_push_s) begin
            tx_mem_q[tx_wptr_q] <= bus.usb_data_i;
        end
    end

`ifdef FT232H_EMU_ERRCHK_EN
    logic err_q, err_d;
    logic oe_n_prev_q;

    // Sticky violation detect: strobes against flags and OE leading RD.
    always_comb begin
        err_d = err_q
              | (~bus.usb_rd_n &  bus.usb_oe_n)
              | (~bus.usb_rd_n &  rxf_n_q)
              | (~bus.usb_wr_n &  txe_n_q)
              | (~bus.usb_wr_n & ~bus.usb_oe_n)
              | (~bus.usb_rd_n &  oe_n_prev_q);
    end

    // Checker registers; previous-cycle OE defaults to deasserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q       <= 1'b0;
            oe_n_prev_q <= 1'b1;
        end else begin
            err_q       <= err_d;
            oe_n_prev_q <= bus.usb_oe_n;
        end
    end

    assign bus.protocol_err = err_q;
`else
    assign bus.protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_ft232h_sync245_emu.sv
// tb_ft232h_sync245_emu
// Directed bench for ft232h_sync245_emu (RX_AW=TX_AW=4, BURST_LEN=8,
// GAP_CYCLES=3). Inputs change and outputs are sampled 1 time unit after
// each rising edge. Build with FT232H_EMU_ERRCHK_EN to expect the checker.
module tb_ft232h_sync245_emu;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    ft232h_sync245_emu_if bus_if ();

    ft232h_sync245_emu #(
        .RX_AW      (4),
        .TX_AW      (4),
        .BURST_LEN  (8),
        .GAP_CYCLES (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    logic [15:0] exp_rxf;
    logic        exp_err;
    int          pops;

    initial begin
        bus_if.usb_data_i = 8'h00;
        bus_if.usb_rd_n   = 1'b1;
        bus_if.usb_oe_n   = 1'b1;
        bus_if.usb_wr_n   = 1'b1;
        bus_if.h2d_data   = 8'h00;
        bus_if.h2d_valid  = 1'b0;
        bus_if.d2h_ready  = 1'b0;

        // ---- reset values ----
        step();
        step();
        chk("rst_rxf_n",   16'(bus_if.usb_rxf_n),    16'd1);
        chk("rst_txe_n",   16'(bus_if.usb_txe_n),    16'd1);
        chk("rst_data_oe", 16'(bus_if.usb_data_oe),  16'd0);
        chk("rst_data_o",  16'(bus_if.usb_data_o),   16'd0);
        chk("rst_h2d_rdy", 16'(bus_if.h2d_ready),    16'd0);
        chk("rst_d2h_vld", 16'(bus_if.d2h_valid),    16'd0);
        chk("rst_d2h_dat", 16'(bus_if.d2h_data),     16'd0);
        chk("rst_err",     16'(bus_if.protocol_err), 16'd0);
        reset = 1'b0;
        step();
        chk("txe_first_edge", 16'(bus_if.usb_txe_n), 16'd0);
        step();
        chk("idle_rxf_n",   16'(bus_if.usb_rxf_n),    16'd1);
        chk("idle_h2d_rdy", 16'(bus_if.h2d_ready),    16'd1);
        chk("idle_d2h_vld", 16'(bus_if.d2h_valid),    16'd0);
        chk("idle_err",     16'(bus_if.protocol_err), 16'd0);

        // ---- three-byte read ----
        bus_if.h2d_valid = 1'b1;
        bus_if.h2d_data = 8'h11; step();
        chk("rxf_after_push", 16'(bus_if.usb_rxf_n), 16'd0);
        bus_if.h2d_data = 8'h22; step();
        bus_if.h2d_data = 8'h33; step();
        bus_if.h2d_valid = 1'b0;
        bus_if.usb_oe_n = 1'b0; step();
        chk("rd3_oe",   16'(bus_if.usb_data_oe), 16'd1);
        chk("rd3_b0",   16'(bus_if.usb_data_o),  16'h11);
        bus_if.usb_rd_n = 1'b0; step();
        chk("rd3_b1",   16'(bus_if.usb_data_o),  16'h22);
        step();
        chk("rd3_b2",   16'(bus_if.usb_data_o),  16'h33);
        step();
        chk("rd3_rxf_empty", 16'(bus_if.usb_rxf_n), 16'd1);
        bus_if.usb_rd_n = 1'b1;
        bus_if.usb_oe_n = 1'b1;
        step();

        // ---- burst gap: 12 bytes, continuous read ----
        bus_if.h2d_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus_if.h2d_data = 8'h40 + 8'(i);
            step();
        end
        bus_if.h2d_valid = 1'b0;
        bus_if.usb_oe_n = 1'b0; step();
        bus_if.usb_rd_n = 1'b0;
        exp_rxf = 16'b0000_0000_1110_0001;
        pops = 0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("burst_rxf_%0d", i), 16'(bus_if.usb_rxf_n), 16'(exp_rxf[15-i]));
            if (bus_if.usb_rxf_n == 1'b0) begin
                chk($sformatf("burst_data_%0d", pops), 16'(bus_if.usb_data_o), 16'h40 + 16'(pops));
                pops++;
            end
            step();
        end
        chk("burst_pops", 16'(pops), 16'd12);
        bus_if.usb_rd_n = 1'b1;
        bus_if.usb_oe_n = 1'b1;
        step();

        // ---- TX fill, drop when full, drain ----
        bus_if.usb_wr_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus_if.usb_data_i = 8'hA0 + 8'(i);
            step();
            if (i == 14) chk("tx_txe_15", 16'(bus_if.usb_txe_n), 16'd0);
        end
        chk("tx_txe_full", 16'(bus_if.usb_txe_n), 16'd1);
        bus_if.usb_data_i = 8'hFF; step();
        bus_if.usb_wr_n = 1'b1;
        chk("tx_head", 16'(bus_if.d2h_data), 16'hA0);
        bus_if.d2h_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tx_vld_%0d", i), 16'(bus_if.d2h_valid), 16'd1);
            chk($sformatf("tx_dat_%0d", i), 16'(bus_if.d2h_data), 16'hA0 + 16'(i));
            step();
        end
        chk("tx_drained", 16'(bus_if.d2h_valid), 16'd0);
        chk("tx_txe_free", 16'(bus_if.usb_txe_n), 16'd0);
        bus_if.d2h_ready = 1'b0;

        // ---- simultaneous push and pop with 5 buffered ----
        bus_if.h2d_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_if.h2d_data = 8'h51 + 8'(i);
            step();
        end
        bus_if.h2d_valid = 1'b0;
        bus_if.usb_oe_n = 1'b0; step();
        chk("sim_head", 16'(bus_if.usb_data_o), 16'h51);
        bus_if.h2d_valid = 1'b1;
        bus_if.h2d_data = 8'h56;
        bus_if.usb_rd_n = 1'b0;
        step();
        bus_if.h2d_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("sim_rxf_%0d", i), 16'(bus_if.usb_rxf_n), 16'd0);
            chk($sformatf("sim_dat_%0d", i), 16'(bus_if.usb_data_o), 16'h52 + 16'(i));
            step();
        end
        chk("sim_empty", 16'(bus_if.usb_rxf_n), 16'd1);
        bus_if.usb_rd_n = 1'b1;
        bus_if.usb_oe_n = 1'b1;
        step();

        // ---- protocol error: rd_n low while oe_n high ----
`ifdef FT232H_EMU_ERRCHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        bus_if.usb_rd_n = 1'b0; step();
        bus_if.usb_rd_n = 1'b1;
        chk("err_set", 16'(bus_if.protocol_err), 16'(exp_err));
        step(); step();
        chk("err_hold", 16'(bus_if.protocol_err), 16'(exp_err));

        // ---- reset mid-stream discards buffered bytes ----
        bus_if.h2d_valid = 1'b1;
        bus_if.h2d_data = 8'h77; step();
        bus_if.h2d_data = 8'h78; step();
        bus_if.h2d_valid = 1'b0;
        reset = 1'b1; step();
        reset = 1'b0; step();
        chk("rst2_rxf_n",  16'(bus_if.usb_rxf_n),    16'd1);
        chk("rst2_data_o", 16'(bus_if.usb_data_o),   16'd0);
        chk("rst2_err",    16'(bus_if.protocol_err), 16'd0);
        chk("rst2_txe_n",  16'(bus_if.usb_txe_n),    16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
